// File: rtl/game_pkg.sv
// Shared encodings for the mole game: state values, LFSR taps and UART command bytes.
// Constants only; no timing or flow-control behaviour lives here.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        PLAY      = 2'd2,
        OVER      = 2'd3
    } game_state_t;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [7:0] CMD_START = 8'h53;  // 'S'
    localparam logic [7:0] CMD_HIT   = 8'h48;  // 'H'

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR exposing its low byte; advances every clock, one-cycle latency.
// No backpressure: the sequence never stalls, consumers sample whenever they need a value.
module mole_lfsr
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] rand_byte
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign rand_byte = lfsr_q[7:0];

endmodule

// File: rtl/mole_game_core.sv
// Whack-a-mole engine: countdown, timed play with expiring moles, hit/miss scoring, high score.
// All outputs registered, inputs act at the next edge; pulse inputs only, no backpressure.
module mole_game_core
    import game_pkg::*;
#(
    parameter int          N_MOLES         = 5,
    parameter int          SCORE_W         = 8,
    parameter int          TIME_W          = 6,
    parameter int          GAME_TICKS      = 30,
    parameter int          COUNTDOWN_TICKS = 3,
    parameter int          MOLE_TICKS      = 2,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    localparam int         IDX_W           = $clog2(N_MOLES)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               tick,
    input  logic [N_MOLES-1:0] hit_mask,
    input  logic               ext_hit,
    output logic [N_MOLES-1:0] mole_mask,
    output logic [IDX_W-1:0]   mole_index,
    output logic               mole_event,
    output logic [1:0]         state,
    output logic [3:0]         countdown,
    output logic [TIME_W-1:0]  time_left,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] miss_count,
    output logic [SCORE_W-1:0] high_score,
    output logic               game_done
);

    localparam int AGE_W = (MOLE_TICKS > 1) ? $clog2(MOLE_TICKS) : 1;

    game_state_t        state_q, state_d;
    logic [3:0]         countdown_q, countdown_d;
    logic [TIME_W-1:0]  time_left_q, time_left_d;
    logic [SCORE_W-1:0] score_q, score_d, miss_q, miss_d, high_q, high_d;
    logic [N_MOLES-1:0] mole_mask_q, mole_mask_d, mask_after;
    logic [IDX_W-1:0]   mole_index_q, mole_index_d;
    logic               mole_event_q, mole_event_d, game_done_q, game_done_d;
    logic [AGE_W-1:0]   age_q, age_d;
    logic               hit, expire, spawn;
    logic [7:0]         rand_byte, cand_mod;
    logic [IDX_W-1:0]   cand, spawn_idx;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clock     (clock),
        .reset     (reset),
        .rand_byte (rand_byte)
    );

    // Step past the previous position so the same hole never lights twice in a row
    assign cand_mod  = rand_byte % 8'(N_MOLES);
    assign cand      = IDX_W'(cand_mod);
    assign spawn_idx = (cand != mole_index_q) ? cand :
                       (cand == IDX_W'(N_MOLES - 1)) ? '0 : cand + IDX_W'(1);

    always_comb begin
        state_d      = state_q;
        countdown_d  = countdown_q;
        time_left_d  = time_left_q;
        score_d      = score_q;
        miss_d       = miss_q;
        high_d       = high_q;
        mole_mask_d  = mole_mask_q;
        mole_index_d = mole_index_q;
        age_d        = age_q;
        mole_event_d = 1'b0;
        game_done_d  = 1'b0;
        hit          = 1'b0;
        expire       = 1'b0;
        spawn        = 1'b0;
        mask_after   = mole_mask_q;

        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d     = COUNTDOWN;
                    countdown_d = 4'(COUNTDOWN_TICKS);
                    score_d     = '0;
                    miss_d      = '0;
                end
            end
            COUNTDOWN: begin
                if (tick) begin
                    if (countdown_q == 4'd1) begin
                        state_d     = PLAY;
                        countdown_d = '0;
                        time_left_d = TIME_W'(GAME_TICKS);
                        spawn       = 1'b1;
                    end else begin
                        countdown_d = countdown_q - 4'd1;
                    end
                end
            end
            PLAY: begin
                hit = (|(hit_mask & mole_mask_q)) || (ext_hit && (|mole_mask_q));
                if (hit) begin
                    score_d    = sat_inc(score_q);
                    mask_after = '0;
                end else if (|hit_mask) begin
                    miss_d = sat_inc(miss_q);
                end
                mole_mask_d = mask_after;
                if (tick) begin
                    if (time_left_q == TIME_W'(1)) begin
                        // A mole still up on the final tick is not charged as a miss
                        state_d     = OVER;
                        time_left_d = '0;
                        mole_mask_d = '0;
                        game_done_d = 1'b1;
                        if (score_d > high_q) high_d = score_d;
                    end else begin
                        time_left_d = time_left_q - TIME_W'(1);
                        expire = (|mask_after) && (age_q == AGE_W'(MOLE_TICKS - 1));
                        if (expire) miss_d = sat_inc(miss_d);
                        if (!(|mask_after) || expire) spawn = 1'b1;
                        else age_d = age_q + AGE_W'(1);
                    end
                end
            end
            default: ;
        endcase

        if (spawn) begin
            mole_mask_d  = {{(N_MOLES-1){1'b0}}, 1'b1} << spawn_idx;
            mole_index_d = spawn_idx;
            mole_event_d = 1'b1;
            age_d        = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            countdown_q  <= '0;
            time_left_q  <= '0;
            score_q      <= '0;
            miss_q       <= '0;
            high_q       <= '0;
            mole_mask_q  <= '0;
            mole_index_q <= '0;
            mole_event_q <= 1'b0;
            game_done_q  <= 1'b0;
            age_q        <= '0;
        end else begin
            state_q      <= state_d;
            countdown_q  <= countdown_d;
            time_left_q  <= time_left_d;
            score_q      <= score_d;
            miss_q       <= miss_d;
            high_q       <= high_d;
            mole_mask_q  <= mole_mask_d;
            mole_index_q <= mole_index_d;
            mole_event_q <= mole_event_d;
            game_done_q  <= game_done_d;
            age_q        <= age_d;
        end
    end

    assign state      = state_q;
    assign countdown  = countdown_q;
    assign time_left  = time_left_q;
    assign score      = score_q;
    assign miss_count = miss_q;
    assign high_score = high_q;
    assign mole_mask  = mole_mask_q;
    assign mole_index = mole_index_q;
    assign mole_event = mole_event_q;
    assign game_done  = game_done_q;

endmodule

// File: tb/tb_mole_game_core.sv
// Directed bench for mole_game_core with a scoreboard queue of expected outputs.
module tb_mole_game_core;

    logic       clk = 1'b0;
    logic       reset, start, tick, ext_hit;
    logic [4:0] hit_mask;
    logic [4:0] mole_mask;
    logic [2:0] mole_index;
    logic       mole_event, game_done;
    logic [1:0] state;
    logic [3:0] countdown;
    logic [5:0] time_left;
    logic [7:0] score, miss_count, high_score;

    int checks = 0;
    int failures = 0;

    string       q_name[$];
    int          q_id[$];
    logic [31:0] q_val[$];

    logic [15:0] lm;
    int          exp_idx;
    logic [4:0]  exp_mask;
    logic [4:0]  hm;

    always #5 clk = ~clk;

    mole_game_core #(
        .N_MOLES(5), .SCORE_W(8), .TIME_W(6), .GAME_TICKS(5),
        .COUNTDOWN_TICKS(3), .MOLE_TICKS(2), .LFSR_SEED(16'hACE1)
    ) dut (
        .clock(clk), .reset(reset), .start(start), .tick(tick),
        .hit_mask(hit_mask), .ext_hit(ext_hit), .mole_mask(mole_mask),
        .mole_index(mole_index), .mole_event(mole_event), .state(state),
        .countdown(countdown), .time_left(time_left), .score(score),
        .miss_count(miss_count), .high_score(high_score), .game_done(game_done)
    );

    // Reference LFSR: x^16+x^14+x^13+x^11+1, seeded on reset, stepping every clock
    always @(posedge clk) begin
        if (!reset) lm <= 16'hACE1;
        else        lm <= (lm >> 1) ^ (lm[0] ? 16'hB400 : 16'h0000);
    end

    function automatic logic [31:0] obs(input int id);
        case (id)
            0: return 32'(state);
            1: return 32'(countdown);
            2: return 32'(time_left);
            3: return 32'(score);
            4: return 32'(miss_count);
            5: return 32'(high_score);
            6: return 32'(mole_mask);
            7: return 32'(mole_index);
            8: return 32'(mole_event);
            default: return 32'(game_done);
        endcase
    endfunction

    function automatic int pred_idx(input logic [15:0] l, input int prev);
        int c;
        c = int'(l[7:0]) % 5;
        if (c == prev) c = (c + 1) % 5;
        return c;
    endfunction

    task automatic expv(input string n, input int id, input logic [31:0] v);
        q_name.push_back(n);
        q_id.push_back(id);
        q_val.push_back(v);
    endtask

    // Next edge spawns: index comes from the LFSR value the DUT will sample
    task automatic exp_spawn();
        exp_idx  = pred_idx(lm, exp_idx);
        exp_mask = 5'b00001 << exp_idx;
        expv("spawn_mask", 6, 32'(exp_mask));
        expv("spawn_index", 7, 32'(exp_idx));
        expv("spawn_event", 8, 32'd1);
    endtask

    task automatic check_q();
        string       n;
        int          id;
        logic [31:0] v, o;
        while (q_id.size() > 0) begin
            n  = q_name.pop_front();
            id = q_id.pop_front();
            v  = q_val.pop_front();
            o  = obs(id);
            checks++;
            assert (o === v) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", n, o, v);
            end
        end
    endtask

    task automatic step(input logic s, input logic t, input logic [4:0] h, input logic e);
        start = s; tick = t; hit_mask = h; ext_hit = e;
        @(negedge clk);
        start = 1'b0; tick = 1'b0; hit_mask = '0; ext_hit = 1'b0;
        check_q();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; tick = 1'b0; hit_mask = '0; ext_hit = 1'b0;
        exp_idx = 0; exp_mask = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        for (int i = 0; i < 10; i++) expv("reset_out", i, 32'd0);
        check_q();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            expv("idle_state", 0, 32'd0);
            expv("idle_cd", 1, 32'd0);
            step(1'b0, 1'b1, '0, 1'b0);
        end

        // Countdown into play
        expv("cd_state", 0, 32'd1); expv("cd3", 1, 32'd3);
        expv("cd_score", 3, 32'd0); expv("cd_miss", 4, 32'd0);
        step(1'b1, 1'b0, '0, 1'b0);
        expv("cd2", 1, 32'd2); step(1'b0, 1'b1, '0, 1'b0);
        expv("cd1", 1, 32'd1); step(1'b0, 1'b1, '0, 1'b0);
        expv("play_state", 0, 32'd2); expv("play_cd", 1, 32'd0);
        expv("play_tl", 2, 32'd5); exp_spawn();
        step(1'b0, 1'b1, '0, 1'b0);
        expv("event_drop", 8, 32'd0); expv("mask_hold", 6, 32'(exp_mask));
        step(1'b0, 1'b0, '0, 1'b0);

        // Hit, wrong press, ext_hit without a mole, start ignored in play
        expv("hit_score", 3, 32'd1); expv("hit_mask0", 6, 32'd0); expv("hit_miss", 4, 32'd0);
        step(1'b0, 1'b0, exp_mask, 1'b0);
        exp_mask = '0;
        expv("wrong_miss", 4, 32'd1); expv("wrong_score", 3, 32'd1);
        step(1'b0, 1'b0, 5'b00001, 1'b0);
        expv("ext_score", 3, 32'd1); expv("ext_miss", 4, 32'd1); expv("ext_mask", 6, 32'd0);
        step(1'b0, 1'b0, '0, 1'b1);
        expv("start_ign", 0, 32'd2); expv("start_ign_tl", 2, 32'd5);
        step(1'b1, 1'b0, '0, 1'b0);

        // Expiry after two ticks, then hit and tick together
        expv("tl4", 2, 32'd4); expv("tl4_miss", 4, 32'd1); exp_spawn();
        step(1'b0, 1'b1, '0, 1'b0);
        expv("tl3", 2, 32'd3); expv("age_mask", 6, 32'(exp_mask));
        expv("age_event", 8, 32'd0); expv("age_miss", 4, 32'd1);
        step(1'b0, 1'b1, '0, 1'b0);
        expv("tl2", 2, 32'd2); expv("expire_miss", 4, 32'd2); exp_spawn();
        step(1'b0, 1'b1, '0, 1'b0);
        expv("tl1", 2, 32'd1); expv("hittick_score", 3, 32'd2);
        expv("hittick_miss", 4, 32'd2); exp_spawn();
        step(1'b0, 1'b1, '0, 1'b1);

        // Final tick
        expv("over_state", 0, 32'd3); expv("over_tl", 2, 32'd0); expv("over_mask", 6, 32'd0);
        expv("over_done", 9, 32'd1); expv("over_high", 5, 32'd2);
        expv("over_score", 3, 32'd2); expv("over_nomiss", 4, 32'd2);
        step(1'b0, 1'b1, '0, 1'b0);
        exp_mask = '0;
        expv("done_drop", 9, 32'd0); expv("over_hold", 0, 32'd3);
        step(1'b0, 1'b0, '0, 1'b0);

        // Second game scoring 1
        expv("re_state", 0, 32'd1); expv("re_cd", 1, 32'd3); expv("re_score", 3, 32'd0);
        expv("re_miss", 4, 32'd0); expv("re_high", 5, 32'd2);
        step(1'b1, 1'b0, '0, 1'b0);
        expv("cd_start_ign", 1, 32'd3); expv("cd_start_state", 0, 32'd1);
        step(1'b1, 1'b0, '0, 1'b0);
        expv("cd_hit_ign", 3, 32'd0); expv("cd_hit_miss", 4, 32'd0); expv("re_cd2", 1, 32'd2);
        step(1'b0, 1'b1, 5'b11111, 1'b1);
        expv("re_cd1", 1, 32'd1); step(1'b0, 1'b1, '0, 1'b0);
        expv("re_play", 0, 32'd2); expv("re_tl", 2, 32'd5); exp_spawn();
        step(1'b0, 1'b1, '0, 1'b0);
        hm = exp_mask | ((exp_mask == 5'b00001) ? 5'b00010 : 5'b00001);
        expv("multi_score", 3, 32'd1); expv("multi_miss", 4, 32'd0); expv("multi_mask", 6, 32'd0);
        step(1'b0, 1'b0, hm, 1'b0);
        expv("g2_tl4", 2, 32'd4); exp_spawn(); step(1'b0, 1'b1, '0, 1'b0);
        expv("g2_tl3", 2, 32'd3); expv("g2_ev0", 8, 32'd0); step(1'b0, 1'b1, '0, 1'b0);
        expv("g2_tl2", 2, 32'd2); expv("g2_expire", 4, 32'd1); exp_spawn();
        step(1'b0, 1'b1, '0, 1'b0);
        expv("g2_tl1", 2, 32'd1); expv("g2_miss1", 4, 32'd1); step(1'b0, 1'b1, '0, 1'b0);
        expv("g2_over", 0, 32'd3); expv("g2_done", 9, 32'd1); expv("g2_high", 5, 32'd2);
        expv("g2_score", 3, 32'd1); expv("g2_lastmiss", 4, 32'd1); expv("g2_mask", 6, 32'd0);
        step(1'b0, 1'b1, '0, 1'b0);

        // Reset mid-play alongside a hit and a tick
        expv("g3_cd", 1, 32'd3); step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        expv("g3_play", 0, 32'd2); exp_spawn();
        step(1'b0, 1'b1, '0, 1'b0);
        reset = 1'b0;
        expv("rst_state", 0, 32'd0); expv("rst_score", 3, 32'd0); expv("rst_high", 5, 32'd0);
        expv("rst_mask", 6, 32'd0); expv("rst_miss", 4, 32'd0); expv("rst_tl", 2, 32'd0);
        step(1'b0, 1'b1, exp_mask, 1'b0);
        reset = 1'b1;
        exp_idx = 0; exp_mask = '0;
        expv("post_rst_state", 0, 32'd0); expv("post_rst_event", 8, 32'd0);
        step(1'b0, 1'b1, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
